dec7_scan_ctrl: RTL
===================

// Module: dec7_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for a NUM_DIGITS-digit 7-segment display sharing one dec7 decoder.
//   Accepts a packed BCD word over a valid/ready handshake and holds it in a pending buffer.
//   Applies the buffered value only at frame boundaries, so a frame never mixes two values.
//   Cycles the digit selects with a programmable on-time and an all-off dead time between digits.
//   Sits between the AXI-lite register slice (value writes) and the board display pins.
// PARAMETERS
//   NUM_DIGITS  4      digits scanned; legal 1..8
//   TICK_DIV    50000  clk cycles each digit is driven (on-time); legal >=1
//   BLANK_CYC   16     all-off dead-time cycles between digits; 0 = no dead time
// PORTS
//   clk          in   1              single clock, rising edge
//   rst          in   1              asynchronous, active-high reset
//   wr_valid     in   1              new display value offered
//   wr_ready     out  1              pending buffer empty; write accepted when valid&&ready
//   wr_data      in   4*NUM_DIGITS   packed BCD; [3:0] = digit 0 (least significant)
//   lz_blank_en  in   1              1 = blank leading zeros (digit 0 never blanked)
//   seg_out      out  7              segments {a,b,c,d,e,f,g}, active-high, registered
//   dig_sel      out  NUM_DIGITS     one-hot digit enable, active-high, registered
//   frame_done   out  1              1-cycle pulse when digit NUM_DIGITS-1 finishes (incl. its blank)
// BEHAVIOUR
//   Reset values: seg_out=0, dig_sel=0, frame_done=0, active value=0, pending empty, state=SHOW, idx=0, prescaler=0.
//   wr_ready = !pend_vld (combinational; 1 during and after reset).
//   Accept: valid&&ready -> pend_data<=wr_data, pend_vld<=1. wr_data is ignored when ready=0; no overwrite.
//   FSM
//     SHOW: prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 clear prescaler.
//       If BLANK_CYC>0, go to BLANK. Otherwise advance idx and stay in SHOW.
//     BLANK: counts 0..BLANK_CYC-1; at end, advance idx and return to SHOW.
//   Advance: idx wraps NUM_DIGITS-1 -> 0. On wrap, frame_done pulses for that cycle.
//     If pend_vld on wrap: active<=pend_data and pend_vld<=0.
//   Simultaneous accept and wrap with pend_vld=0: the write enters pending and applies at the NEXT wrap.
//   Outputs, registered, 1-cycle lag from state:
//     In SHOW: dig_sel = 1<<idx; seg_out = dec7(active[4*idx+:4]), or 0 if idx is leading-blanked.
//     In BLANK: dig_sel = 0 and seg_out = 0.
//   Leading-zero rule: when lz_blank_en=1, digit k>0 is blanked iff active nibbles k..NUM_DIGITS-1 are all 0.
//     lz_blank_en is sampled combinationally each cycle.
//   Nibbles >9 decode to 7'b0 (dec7 default), i.e. blank.
//   Timing: digit period = TICK_DIV+BLANK_CYC cycles; frame period = NUM_DIGITS*(TICK_DIV+BLANK_CYC) cycles.
//   Reset mid-scan: all outputs go to reset values immediately (async), pending value is lost,
//     and the scan restarts at digit 0 with prescaler 0.
//   NUM_DIGITS=1: idx is constant 0, and every digit period is a wrap.
// STRUCTURE
//   dec7_pkg:
//     SEG_BLANK=7'b0000000
//     BCD_W=4
//     scan_state_t enum {SHOW, BLANK}
//     function clog2_min1(n), used for idx and counter widths
//   Counter widths: prescaler clog2_min1(TICK_DIV); blank counter clog2_min1(BLANK_CYC); idx clog2_min1(NUM_DIGITS).
//   One sub-module instance, u_dec7 (dec7): its input is the nibble mux output, its output feeds the seg_out register.
//   Everything else (handshake, pending buffer, FSM, counters, leading-zero mask) is inline in this module.
// TESTING  (NUM_DIGITS=4, TICK_DIV=4, BLANK_CYC=2 unless noted)
//   1. Release reset, no writes.
//      -> Both outputs are 0 for 1 cycle, then dig_sel=0001 with seg_out=7'b1111110 for 4 cycles.
//      -> Then 2 cycles of dig_sel=0.
//      -> Then 0010, 0100, 1000; frame_done pulses every 24 cycles.
//   2. Write 16'h1234 mid-frame.
//      -> wr_ready drops.
//      -> Digits keep showing 0 until the wrap; the next frame shows
//         digit0=7'b0110011, d1=7'b1111001, d2=7'b1101101, d3=7'b0110000.
//      -> wr_ready rises at the wrap cycle.
//   3. Second write while pending is full.
//      -> Not accepted (ready=0); the first value is displayed; the second is accepted on the cycle after the wrap.
//   4. lz_blank_en=1, write 16'h0070.
//      -> digit0 = 7'b1111110 and digit1 = 7'b1110010.
//      -> digits 2-3 have dig_sel asserted and seg_out=0.
//      -> With 16'h0000: only digit0 shows 7'b1111110.
//   5. Write 16'hA9F5.
//      -> digit3 and digit1 show seg_out=0; digit2 shows 7'b1111011; digit0 shows 7'b1011011.
//   6. Assert rst during BLANK of digit 2 with a write pending.
//      -> Outputs are 0 asynchronously.
//      -> After release, the scan restarts at digit 0 showing 7'b1111110, and wr_ready=1.
//   7. BLANK_CYC=0.
//      -> dig_sel advances every 4 cycles with no all-off cycle; frame_done every 16 cycles.

Source files
------------

// File: rtl/dec7_pkg.sv
// dec7_pkg: shared constants, scan state type and width helper for the 7-segment scan controller
package dec7_pkg;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam int BCD_W = 4;
    typedef enum logic {SHOW, BLANK} scan_state_t;
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/dec7.sv
// dec7: BCD nibble to 7-segment {a,b,c,d,e,f,g} active-high decoder; non-BCD nibbles decode blank
//   bcd in 4  nibble to decode
//   seg out 7 segment pattern
module dec7
    import dec7_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);
    always_comb begin
        case (bcd)
            4'd0: seg = 7'b1111110;
            4'd1: seg = 7'b0110000;
            4'd2: seg = 7'b1101101;
            4'd3: seg = 7'b1111001;
            4'd4: seg = 7'b0110011;
            4'd5: seg = 7'b1011011;
            4'd6: seg = 7'b1011111;
            4'd7: seg = 7'b1110010;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1111011;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/dec7_scan_ctrl.sv
// dec7_scan_ctrl: time-multiplexed NUM_DIGITS-digit 7-segment scanner with frame-aligned value updates
//   clk, rst     clock, asynchronous active-high reset
//   wr_valid/wr_ready/wr_data  packed BCD value handshake into a one-deep pending buffer
//   lz_blank_en  blank leading zeros (digit 0 always shown)
//   seg_out      registered segments {a..g}; dig_sel registered one-hot digit enable
//   frame_done   one-cycle pulse as the last digit (with its dead time) completes
module dec7_scan_ctrl
    import dec7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [BCD_W*NUM_DIGITS-1:0] wr_data,
    input  logic                        lz_blank_en,
    output logic [6:0]                  seg_out,
    output logic [NUM_DIGITS-1:0]       dig_sel,
    output logic                        frame_done
);
    localparam int DW = BCD_W * NUM_DIGITS;
    localparam int IW = clog2_min1(NUM_DIGITS);
    localparam int PW = clog2_min1(TICK_DIV);
    localparam int BW = clog2_min1(BLANK_CYC);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLANK_CYC > 0 ? BLANK_CYC - 1 : 0);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

    scan_state_t           state, state_n;
    logic [PW-1:0]         presc, presc_n;
    logic [BW-1:0]         bcnt, bcnt_n;
    logic [IW-1:0]         idx, idx_n;
    logic                  adv, wrap;
    logic [DW-1:0]         active, pend_data;
    logic                  pend_vld;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_above, lz_hit;
    logic [BCD_W-1:0]      nib;
    logic [6:0]            seg_dec;

    assign wr_ready = !pend_vld;

    always_comb begin
        state_n = state;
        presc_n = presc;
        bcnt_n  = bcnt;
        idx_n   = idx;
        adv     = 1'b0;
        if (state == SHOW) begin
            presc_n = presc + 1'b1;
            if (presc == P_LAST) begin
                presc_n = '0;
                if (BLANK_CYC > 0) state_n = BLANK;
                else adv = 1'b1;
            end
        end else begin
            bcnt_n = bcnt + 1'b1;
            if (bcnt == B_LAST) begin
                bcnt_n  = '0;
                state_n = SHOW;
                adv     = 1'b1;
            end
        end
        wrap = adv && (idx == I_LAST);
        if (adv) idx_n = wrap ? '0 : idx + 1'b1;
    end

    // A digit is leading-blanked when it and every more significant nibble are zero.
    always_comb begin
        zero_above = 1'b1;
        lz_mask    = '0;
        nib        = '0;
        lz_hit     = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (active[k*BCD_W +: BCD_W] == '0);
            lz_mask[k] = lz_blank_en && (k != 0) && zero_above;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib    = active[k*BCD_W +: BCD_W];
                lz_hit = lz_mask[k];
            end
        end
    end

    dec7 u_dec7 (.bcd(nib), .seg(seg_dec));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SHOW;
            presc      <= '0;
            bcnt       <= '0;
            idx        <= '0;
            active     <= '0;
            pend_data  <= '0;
            pend_vld   <= 1'b0;
            seg_out    <= SEG_BLANK;
            dig_sel    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            presc      <= presc_n;
            bcnt       <= bcnt_n;
            idx        <= idx_n;
            // Accept only when empty, so it never coincides with the wrap-time transfer.
            if (wr_valid && wr_ready) begin
                pend_data <= wr_data;
                pend_vld  <= 1'b1;
            end else if (wrap && pend_vld) begin
                active   <= pend_data;
                pend_vld <= 1'b0;
            end
            seg_out    <= (state == SHOW && !lz_hit) ? seg_dec : SEG_BLANK;
            dig_sel    <= (state == SHOW) ? NUM_DIGITS'(1) << idx : '0;
            frame_done <= wrap;
        end
    end
endmodule
